qed_dup_queue: RTL and testbench

QED_DUP_QUEUE -- requirements
Module: qed_dup_queue

---
 rtl/qed_dup_queue.sv | 183 ++++++++++++++++++
 tb/tb_qed_dup_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_queue.sv
// qed_dup_queue: QED duplicate-instruction queue.
// In ORIG mode fetched instructions are forwarded unchanged and recorded in a
// FIFO. On exe_dup the FIFO is replayed with every used register field moved
// to its bit-4 shadow (x1..x15 -> x17..x31). After replay the block waits until
// the retired original and duplicate counts match. It then pulses
// qed_check_valid/sif_commit, clears the counts and returns to ORIG.
//
// Optional feature: define QED_REMAP_X0_EN to also remap x0 fields to x16.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_in, instr_valid     fetch beat offered to the block
//   instr_ready               block accepts the fetch beat this cycle
//   exe_dup                   request to switch to duplicate replay
//   commit, commit_dup        one retirement this cycle, and whether it was a duplicate
//   instr_out, instr_out_valid  registered issue beat to the pipeline
//   qed_num_orig, qed_num_dup retired original / duplicate counts
//   sif_state                 0 ORIG, 1 DUP, 2 WAIT
//   qed_check_valid, sif_commit  one-cycle pulses at a QED-consistent point
module qed_dup_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr_in,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          exe_dup,
  input  logic          commit,
  input  logic          commit_dup,
  output logic [31:0]   instr_out,
  output logic          instr_out_valid,
  output logic [AW:0]   qed_num_orig,
  output logic [AW:0]   qed_num_dup,
  output logic [1:0]    sif_state,
  output logic          qed_check_valid,
  output logic          sif_commit
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

`ifdef QED_REMAP_X0_EN
  localparam logic X0_EN = 1'b1;
`else
  localparam logic X0_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    S_ORIG = 2'd0,
    S_DUP  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e        state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   orig_q, orig_d, dup_q, dup_d;
  logic [31:0]   out_q;
  logic          out_valid_q;
  logic          ready_q;
  logic          pulse_q;

  logic          push, pop, go_dup, wait_done;
  logic [AW:0]   orig_base, dup_base;

  // Set bit 4 of each register field the opcode actually uses.
  function automatic logic [31:0] remap(input logic [31:0] i);
    logic [31:0] o;
    logic        use_rd, use_rs1, use_rs2;
    o       = i;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (i[6:0])
      OP_R:              begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_I, OP_LOAD:     begin use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_S, OP_B:        begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LUI, OP_AUIPC:  begin use_rd = 1'b1; end
      default:           ;
    endcase
    if (use_rd  && (X0_EN || i[11:7]  != 5'd0)) o[11] = 1'b1;
    if (use_rs1 && (X0_EN || i[19:15] != 5'd0)) o[19] = 1'b1;
    if (use_rs2 && (X0_EN || i[24:20] != 5'd0)) o[24] = 1'b1;
    return o;
  endfunction

  // Queue occupancy and mode-switch decision; a same-cycle push counts first.
  always_comb begin
    push    = (state_q == S_ORIG) && instr_valid && ready_q;
    pop     = (state_q == S_DUP) && (count_q != '0);
    count_d = count_q;
    if (push) begin
      count_d = count_q + 1'b1;
    end else if (pop) begin
      count_d = count_q - 1'b1;
    end
    go_dup    = (state_q == S_ORIG) && exe_dup && (count_d != '0);
    wait_done = (state_q == S_WAIT) && (dup_q == orig_q) && (orig_q != '0);
  end

  // Retirement counters; a commit in the clearing cycle lands after the clear.
  always_comb begin
    orig_base = wait_done ? '0 : orig_q;
    dup_base  = wait_done ? '0 : dup_q;
    orig_d    = orig_base;
    dup_d     = dup_base;
    if (commit) begin
      if (commit_dup) begin
        if (dup_base < DEPTH_W) dup_d = dup_base + 1'b1;
      end else begin
        if (orig_base < DEPTH_W) orig_d = orig_base + 1'b1;
      end
    end
  end

  // Queue storage: not reset, only written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= instr_in;
  end

  // Mode FSM, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ORIG;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      orig_q      <= '0;
      dup_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      pulse_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      orig_q      <= orig_d;
      dup_q       <= dup_d;
      out_valid_q <= 1'b0;
      pulse_q     <= 1'b0;
      if (push) begin
        tail_q      <= tail_q + 1'b1;
        out_q       <= instr_in;
        out_valid_q <= 1'b1;
      end
      if (pop) begin
        head_q      <= head_q + 1'b1;
        out_q       <= remap(mem_q[head_q]);
        out_valid_q <= 1'b1;
      end
      case (state_q)
        S_ORIG: if (go_dup) state_q <= S_DUP;
        S_DUP:  if (count_d == '0) state_q <= S_WAIT;
        S_WAIT: if (wait_done) begin
          state_q <= S_ORIG;
          pulse_q <= 1'b1;
        end
        default: state_q <= S_ORIG;
      endcase
      // Ready reflects the mode and fill level the next cycle will see.
      ready_q <= (((state_q == S_ORIG) && !go_dup) || wait_done) && (count_d != DEPTH_W);
    end
  end

  assign instr_ready     = ready_q;
  assign instr_out       = out_q;
  assign instr_out_valid = out_valid_q;
  assign qed_num_orig    = orig_q;
  assign qed_num_dup     = dup_q;
  assign sif_state       = 2'(state_q);
  assign qed_check_valid = pulse_q;
  assign sif_commit      = pulse_q;

endmodule

// File: tb/tb_qed_dup_queue.sv
`timescale 1ns/1ps
module tb_qed_dup_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef QED_REMAP_X0_EN
  localparam bit X0_EN = 1'b1;
`else
  localparam bit X0_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   instr_in = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic          exe_dup = 1'b0;
  logic          commit = 1'b0;
  logic          commit_dup = 1'b0;
  logic [31:0]   instr_out;
  logic          instr_out_valid;
  logic [AW:0]   qed_num_orig, qed_num_dup;
  logic [1:0]    sif_state;
  logic          qed_check_valid, sif_commit;

  always #5 clk = ~clk;

  qed_dup_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .exe_dup(exe_dup), .commit(commit), .commit_dup(commit_dup),
    .instr_out(instr_out), .instr_out_valid(instr_out_valid),
    .qed_num_orig(qed_num_orig), .qed_num_dup(qed_num_dup),
    .sif_state(sif_state),
    .qed_check_valid(qed_check_valid), .sif_commit(sif_commit)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mq[$];
  int m_state = 0;
  int m_orig = 0;
  int m_dup = 0;
  bit m_pulse = 1'b0;
  bit live = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tb_remap(input logic [31:0] i);
    logic [31:0] r;
    logic [2:0]  f;
    r = i;
    case (i[6:0])
      7'b0110011:             f = 3'b111;
      7'b0010011, 7'b0000011: f = 3'b110;
      7'b0100011, 7'b1100011: f = 3'b011;
      7'b0110111, 7'b0010111: f = 3'b100;
      default:                f = 3'b000;
    endcase
    if (f[2] && (X0_EN || i[11:7]  != 5'd0)) r[11] = 1'b1;
    if (f[1] && (X0_EN || i[19:15] != 5'd0)) r[19] = 1'b1;
    if (f[0] && (X0_EN || i[24:20] != 5'd0)) r[24] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: r[6:0] = 7'b1100011;
      5: r[6:0] = 7'b0110111;
      default: r[6:0] = 7'b0010111;
    endcase
    r[11] = 1'b0;
    r[19] = 1'b0;
    r[24] = 1'b0;
    return r;
  endfunction

  // One clock: predict from the current inputs, advance, then compare.
  task automatic cycle();
    logic [31:0] x;
    logic [31:0] e;
    if (live) chk("ready", 32'(instr_ready), 32'(m_state == 0 && mq.size() < DEPTH));
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_state = 0;
      m_orig  = 0;
      m_dup   = 0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      case (m_state)
        0: begin
          if (instr_valid && mq.size() < DEPTH) begin
            mq.push_back(instr_in);
            exp_q.push_back(instr_in);
          end
          if (exe_dup && mq.size() > 0) m_state = 1;
        end
        1: begin
          x = mq.pop_front();
          exp_q.push_back(tb_remap(x));
          if (mq.size() == 0) m_state = 2;
        end
        default: begin
          if (m_orig == m_dup && m_orig != 0) begin
            m_pulse = 1'b1;
            m_orig  = 0;
            m_dup   = 0;
            m_state = 0;
          end
        end
      endcase
      if (commit) begin
        if (commit_dup) begin
          if (m_dup < DEPTH) m_dup++;
        end else if (m_orig < DEPTH) begin
          m_orig++;
        end
      end
    end
    @(posedge clk);
    #1;
    live = 1'b1;
    chk("out_valid", 32'(instr_out_valid), 32'(exp_q.size() != 0));
    if (instr_out_valid === 1'b1 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("instr_out", instr_out, e);
    end
    chk("sif_state", 32'(sif_state), 32'(m_state));
    chk("num_orig", 32'(qed_num_orig), 32'(m_orig));
    chk("num_dup", 32'(qed_num_dup), 32'(m_dup));
    chk("check_valid", 32'(qed_check_valid), 32'(m_pulse));
    chk("sif_commit", 32'(sif_commit), 32'(m_pulse));
  endtask

  task automatic push(input logic [31:0] x);
    instr_in = x;
    instr_valid = 1'b1;
    cycle();
    instr_valid = 1'b0;
  endtask

  task automatic run_dup();
    exe_dup = 1'b1;
    cycle();
    exe_dup = 1'b0;
    for (int k = 0; k < DEPTH + 1 && m_state == 1; k++) cycle();
  endtask

  task automatic commits(input int n, input bit d);
    for (int k = 0; k < n; k++) begin
      commit = 1'b1;
      commit_dup = d;
      cycle();
    end
    commit = 1'b0;
    commit_dup = 1'b0;
  endtask

  task automatic drain(input int n);
    commits(n, 1'b0);
    commits(n, 1'b1);
    cycle();
    chk("drain_pulse", 32'(qed_check_valid), 32'd1);
    chk("drain_state", 32'(sif_state), 32'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_out", instr_out, 32'h0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_state", 32'(sif_state), 32'd0);

    // ADD x3,x1,x2 pushed together with exe_dup
    instr_in = 32'h002081B3;
    instr_valid = 1'b1;
    exe_dup = 1'b1;
    cycle();
    instr_valid = 1'b0;
    exe_dup = 1'b0;
    chk("add_fwd", instr_out, 32'h002081B3);
    chk("add_state_dup", 32'(sif_state), 32'd1);
    cycle();
    chk("add_remap", instr_out, 32'h012889B3);
    chk("add_state_wait", 32'(sif_state), 32'd2);
    drain(1);
    cycle();
    chk("pulse_one_cycle", 32'(qed_check_valid), 32'd0);

    // ADDI x5,x0,7 with x0 source; commit landing in the clearing cycle
    push(32'h00700293);
    run_dup();
    chk("addi_remap", instr_out, X0_EN ? 32'h00780A93 : 32'h00700A93);
    commits(1, 1'b0);
    commits(1, 1'b1);
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    chk("clear_commit_pulse", 32'(sif_commit), 32'd1);
    chk("clear_commit_orig", 32'(qed_num_orig), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // exe_dup with empty queue is ignored
    exe_dup = 1'b1;
    cycle();
    exe_dup = 1'b0;
    chk("empty_dup_ignored", 32'(sif_state), 32'd0);

    // Three originals, three duplicates, consistency pulse
    for (int k = 0; k < 3; k++) push(rnd_instr());
    run_dup();
    drain(3);
    chk("three_counts_clear", 32'(qed_num_orig), 32'd0);

    // Fill to capacity: 17 offered beats, 16 accepted
    instr_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      instr_in = rnd_instr();
      cycle();
      if (k >= 15) chk("full_not_ready", 32'(instr_ready), 32'd0);
    end
    instr_valid = 1'b0;
    run_dup();
    drain(16);

    // Two batches of 10 across the pointer wrap
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 10; k++) push(rnd_instr());
      run_dup();
      drain(10);
    end

    // Reset in the middle of replay
    for (int k = 0; k < 4; k++) push(rnd_instr());
    exe_dup = 1'b1;
    cycle();
    exe_dup = 1'b0;
    cycle();
    cycle();
    chk("mid_dup_state", 32'(sif_state), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_dup_state", 32'(sif_state), 32'd0);
    chk("rst_dup_valid", 32'(instr_out_valid), 32'd0);
    chk("rst_dup_pulse", 32'(qed_check_valid), 32'd0);
    exe_dup = 1'b1;
    cycle();
    exe_dup = 1'b0;
    chk("rst_dup_empty", 32'(sif_state), 32'd0);

    // Counter saturation at DEPTH
    commits(DEPTH + 2, 1'b0);
    chk("orig_saturate", 32'(qed_num_orig), 32'(DEPTH));
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
